// File: rtl/pow8_arb_if.sv
// rtl/pow8_arb_if.sv - client, pow8-pipeline and result streams around pow8_arb
// slave is the arbiter's view; master is the surrounding clients and pipeline.
interface pow8_arb_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]    s_valid;
  logic [NREQ-1:0]    s_ready;
  logic [32*NREQ-1:0] s_data;
  logic               d_valid;
  logic               d_ready;
  logic [31:0]        d_data;
  logic               r_valid;
  logic               r_ready;
  logic [63:0]        r_data;
  logic [NREQ-1:0]    m_valid;
  logic [NREQ-1:0]    m_ready;
  logic [63:0]        m_data;
  logic               err;

  modport slave (
    input  s_valid, s_data, d_ready, r_valid, r_data, m_ready,
    output s_ready, d_valid, d_data, r_ready, m_valid, m_data, err
  );

  modport master (
    output s_valid, s_data, d_ready, r_valid, r_data, m_ready,
    input  s_ready, d_valid, d_data, r_ready, m_valid, m_data, err
  );
endinterface

// File: rtl/pow8_arb.sv
// rtl/pow8_arb.sv - round-robin share of one in-order pow8 pipeline among NREQ clients
// Define POW8_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module pow8_arb #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  pow8_arb_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

`ifndef POW8_ARB_FIXED_PRIO_EN
  logic [IW-1:0] rr_q, rr_d;
`endif
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          err_q, err_d;
  logic [IW-1:0] tag_q [DEPTH];

  logic          eligible, any_req, nonempty, issue_hs, ret_hs;
  logic [IW-1:0] grant, head, idx;

  assign eligible = count_q < CW'(DEPTH);
  assign any_req  = |bus.s_valid;
  assign nonempty = count_q != '0;
  assign head     = tag_q[rd_q];
  assign issue_hs = bus.d_valid & bus.d_ready;
  assign ret_hs   = bus.r_valid & bus.r_ready;

  // Search from the highest offset down so the last hit is the first in rotation order.
  always_comb begin
    grant = '0;
    idx   = '0;
`ifdef POW8_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.s_valid[i]) grant = IW'(i);
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_q) + k) % NREQ);
      if (bus.s_valid[idx]) grant = idx;
    end
`endif
    if (lock_q) grant = lock_id_q;
  end

  always_comb begin
    bus.d_valid = eligible & any_req;
    bus.d_data  = '0;
    bus.s_ready = '0;
    bus.m_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IW'(i)) begin
        if (bus.d_valid) bus.d_data = bus.s_data[32*i +: 32];
        bus.s_ready[i] = bus.d_valid & bus.d_ready;
      end
      bus.m_valid[i] = bus.r_valid & nonempty & (head == IW'(i));
    end
    bus.r_ready = nonempty & bus.m_ready[head];
    bus.m_data  = bus.r_data;
    bus.err     = err_q;
  end

  always_comb begin
    count_d   = count_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (bus.r_valid & ~nonempty);
`ifndef POW8_ARB_FIXED_PRIO_EN
    rr_d      = rr_q;
    if (issue_hs) rr_d = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
`endif
    if (issue_hs) wr_d = wr_q + 1'b1;
    if (ret_hs)   rd_d = rd_q + 1'b1;
    if (issue_hs && !ret_hs)      count_d = count_q + 1'b1;
    else if (!issue_hs && ret_hs) count_d = count_q - 1'b1;
    // A stalled offer pins the grant so d_data cannot switch requesters mid-offer.
    if (issue_hs) begin
      lock_d = 1'b0;
    end else if (bus.d_valid) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifndef POW8_ARB_FIXED_PRIO_EN
      rr_q      <= '0;
`endif
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      count_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
`ifndef POW8_ARB_FIXED_PRIO_EN
      rr_q      <= rr_d;
`endif
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      count_q   <= count_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_hs) tag_q[wr_q] <= grant;
  end
endmodule

// File: tb/tb_pow8_arb.sv
// tb/tb_pow8_arb.sv - self-checking bench for pow8_arb with a queue-based pipeline and scoreboard
module tb_pow8_arb;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int IW    = 2;
`ifdef POW8_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pow8_arb_if #(.NREQ(NREQ)) bus ();
  pow8_arb #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pow8(input logic [31:0] x);
    logic [63:0] p;
    p = 64'(x);
    p = p * p;
    p = p * p;
    p = p * p;
    return p;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Stand-in pow8 pipeline: in-order queue, results offered whenever pipe_en is high.
  logic [31:0] pipe_q [$];
  int          pipe_n = 0;
  logic [31:0] pipe_head = '0;
  bit          pipe_en = 1'b0;
  bit          force_rv = 1'b0;
  logic [63:0] force_rd = '0;
  bit          iss_seen = 1'b0;
  bit          ret_seen = 1'b0;
  logic [31:0] iss_data = '0;

  assign bus.r_valid = force_rv | (pipe_en & (pipe_n > 0));
  assign bus.r_data  = force_rv ? force_rd : ((pipe_n > 0) ? pow8(pipe_head) : 64'd0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q.delete();
    end else begin
      if (ret_seen) void'(pipe_q.pop_front());
      if (iss_seen) pipe_q.push_back(iss_data);
    end
    pipe_n    = pipe_q.size();
    pipe_head = (pipe_n > 0) ? pipe_q[0] : 32'd0;
  end

  // Reference model: expected grant from rotation/lock rules, in-flight list as a queue.
  typedef struct {
    int          id;
    logic [31:0] x;
  } txn_t;
  txn_t            exp_q [$];
  int              rr_m = 0;
  int              lock_id_m = 0;
  bit              lock_m = 1'b0;
  bit              err_m = 1'b0;
  logic [NREQ-1:0] acc_m = '0;

  always @(negedge clk) begin : mon
    int              g, h, idx;
    bit              dv, ne, rre;
    logic [NREQ-1:0] sv, sre, mve;
    logic [31:0]     op;
    if (rst) begin
      exp_q.delete();
      rr_m = 0; lock_m = 1'b0; lock_id_m = 0; err_m = 1'b0;
      iss_seen = 1'b0; ret_seen = 1'b0; acc_m = '0;
    end else begin
      sv = bus.s_valid;
      g  = -1;
      if (lock_m) g = lock_id_m;
      else begin
        for (int k = 0; k < NREQ; k++) begin
          idx = FP ? k : (rr_m + k) % NREQ;
          if (g < 0 && sv[IW'(idx)]) g = idx;
        end
      end
      if (g < 0) g = 0;
      op  = 32'(bus.s_data >> (32 * g));
      dv  = (exp_q.size() < DEPTH) && (sv != '0);
      sre = (dv && bus.d_ready) ? (NREQ'(1) << g) : '0;
      chk("d_valid", 64'(bus.d_valid), 64'(dv));
      if (dv) chk("d_data", 64'(bus.d_data), 64'(op));
      chk("s_ready", 64'(bus.s_ready), 64'(sre));
      ne  = exp_q.size() > 0;
      h   = ne ? exp_q[0].id : 0;
      mve = (bus.r_valid && ne) ? (NREQ'(1) << h) : '0;
      rre = ne && bus.m_ready[IW'(h)];
      chk("m_valid", 64'(bus.m_valid), 64'(mve));
      chk("r_ready", 64'(bus.r_ready), 64'(rre));
      chk("m_data", bus.m_data, bus.r_data);
      chk("err", 64'(bus.err), 64'(err_m));
      if (bus.r_valid && rre) chk("result", bus.r_data, pow8(exp_q[0].x));
      if (bus.r_valid && !ne) err_m = 1'b1;
      if (bus.r_valid && rre) void'(exp_q.pop_front());
      if (dv && bus.d_ready) begin
        exp_q.push_back('{id: g, x: op});
        rr_m   = (g + 1) % NREQ;
        lock_m = 1'b0;
      end else if (dv) begin
        lock_m    = 1'b1;
        lock_id_m = g;
      end
      acc_m    = bus.s_valid & bus.s_ready;
      iss_seen = bus.d_valid & bus.d_ready;
      iss_data = bus.d_data;
      ret_seen = bus.r_valid & bus.r_ready;
    end
  end

  typedef struct {
    logic [NREQ-1:0] sv;
    logic            dr;
    logic [NREQ-1:0] sr;
    logic            dv;
    logic [31:0]     dd;
  } vec_t;
  vec_t vt [12];

  task automatic drain(input string nm);
    bus.s_valid = '0;
    bus.m_ready = '1;
    pipe_en     = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) next();
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] bp_oh;
    logic [63:0]     bp_val;
    // Requester i offers i+1; rows walk rotation, lock and the full-FIFO boundary from reset.
    vt[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'd0};
    vt[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 32'd3};
    vt[2]  = FP ? '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'd1} : '{4'b1111, 1'b1, 4'b1000, 1'b1, 32'd4};
    vt[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'd1};
    vt[4]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 32'd2};
    vt[5]  = '{4'b1011, 1'b0, 4'b0000, 1'b1, 32'd2};
    vt[6]  = '{4'b1011, 1'b1, 4'b0010, 1'b1, 32'd2};
    vt[7]  = FP ? '{4'b1011, 1'b1, 4'b0001, 1'b1, 32'd1} : '{4'b1011, 1'b1, 4'b1000, 1'b1, 32'd4};
    vt[8]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 32'd1};
    vt[9]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 32'd4};
    vt[10] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 32'd2};
    vt[11] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 32'd0};

    bus.s_valid = '0;
    bus.d_ready = 1'b0;
    bus.m_ready = '0;
    for (int i = 0; i < NREQ; i++) bus.s_data[32*i +: 32] = 32'(i + 1);
    #1;
    chk("rst_d_valid", 64'(bus.d_valid), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_d_data", 64'(bus.d_data), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_r_ready", 64'(bus.r_ready), 64'd0);
    chk("rst_m_data", bus.m_data, 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    next();
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      bus.s_valid = vt[k].sv;
      bus.d_ready = vt[k].dr;
      @(negedge clk);
      chk($sformatf("vec%0d_s_ready", k), 64'(bus.s_ready), 64'(vt[k].sr));
      chk($sformatf("vec%0d_d_valid", k), 64'(bus.d_valid), 64'(vt[k].dv));
      chk($sformatf("vec%0d_d_data", k), 64'(bus.d_data), 64'(vt[k].dd));
      next();
    end

    // FIFO full: one result pops, the freed slot is only usable the following cycle.
    pipe_en     = 1'b1;
    bus.m_ready = '1;
    @(negedge clk);
    chk("full_pop_m_valid", 64'(bus.m_valid), 64'(4'b0100));
    chk("full_pop_m_data", bus.m_data, 64'd6561);
    chk("full_pop_r_ready", 64'(bus.r_ready), 64'd1);
    chk("full_no_bypass", 64'(bus.d_valid), 64'd0);
    next();
    pipe_en = 1'b0;
    @(negedge clk);
    chk("full_reissue_d_valid", 64'(bus.d_valid), 64'd1);
    chk("full_reissue_s_ready", 64'(bus.s_ready), FP ? 64'(4'b0001) : 64'(4'b0100));
    next();
    @(negedge clk);
    chk("full_again_d_valid", 64'(bus.d_valid), 64'd0);
    bus.s_valid = '0;

    bp_oh  = FP ? 4'b0001 : 4'b1000;
    bp_val = FP ? 64'd1 : 64'd65536;
    bus.m_ready = '0;
    pipe_en     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next();
      @(negedge clk);
      chk("bp_r_ready", 64'(bus.r_ready), 64'd0);
      chk("bp_m_valid", 64'(bus.m_valid), 64'(bp_oh));
      chk("bp_m_data", bus.m_data, bp_val);
    end
    next();
    bus.m_ready = '1;
    @(negedge clk);
    chk("bp_release_r_ready", 64'(bus.r_ready), 64'd1);
    chk("bp_release_m_valid", 64'(bus.m_valid), 64'(bp_oh));
    next();
    drain("drain_directed");

    pipe_en  = 1'b0;
    force_rv = 1'b1;
    force_rd = 64'h1234;
    @(negedge clk);
    chk("empty_r_ready", 64'(bus.r_ready), 64'd0);
    chk("empty_m_valid", 64'(bus.m_valid), 64'd0);
    chk("empty_err_before", 64'(bus.err), 64'd0);
    next();
    force_rv = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(bus.err), 64'd1);
    for (int c = 0; c < 3; c++) next();
    @(negedge clk);
    chk("err_sticky", 64'(bus.err), 64'd1);

    // Three tags in flight, then an asynchronous reset between clock edges.
    bus.d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next();
      bus.s_valid = NREQ'(1) << i;
    end
    next();
    bus.s_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_d_valid", 64'(bus.d_valid), 64'd0);
    chk("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("mid_rst_r_ready", 64'(bus.r_ready), 64'd0);
    chk("mid_rst_m_data", bus.m_data, 64'd0);
    chk("mid_rst_err", 64'(bus.err), 64'd0);
    next();
    rst = 1'b0;

    bus.s_valid = '1;
    bus.m_ready = '1;
    pipe_en     = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", c), 64'(bus.s_ready),
          FP ? 64'(4'b0001) : 64'(NREQ'(1) << (c % NREQ)));
      next();
    end
    drain("drain_rr");

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.s_valid[i] && !acc_m[i])) begin
          bus.s_valid[i] = ($urandom_range(0, 2) != 0);
          bus.s_data[32*i +: 32] = $urandom;
        end
      end
      bus.d_ready = ($urandom_range(0, 3) != 0);
      bus.m_ready = NREQ'($urandom);
      pipe_en     = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      next();
    end
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pow8_arb.md
Name: pow8_arb

Overview:
- N-requester scheduler that shares one pow8 pipeline (32-bit in, 64-bit x^8 out, valid/ready both sides, in-order) among several valid/ready clients.
- Round-robin arbitrates requests onto the pipeline input and records each granted requester ID in an in-order tag FIFO.
- Routes each pipeline result back to the requester that issued it.
- Sits between the client streams and a single pow8 instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DEPTH, 8, max in-flight transactions; tag FIFO depth, power of 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- s_valid  input  NREQ  per-requester request valid.
- s_ready  output  NREQ  per-requester request accept.
- s_data  input  32*NREQ  request operand; requester i uses bits [32i+31:32i].
- d_valid  output  1  to pow8 input valid.
- d_ready  input  1  from pow8 input ready.
- d_data  output  32  to pow8 operand.
- r_valid  input  1  from pow8 result valid.
- r_ready  output  1  to pow8 result ready.
- r_data  input  64  from pow8 result.
- m_valid  output  NREQ  per-requester result valid.
- m_ready  input  NREQ  per-requester result accept.
- m_data  output  64  result data, shared by all requesters, equal to r_data.
- err  output  1  sticky: a result arrived with the tag FIFO empty.

Behaviour:
- Reset (async, rst=1):
  - rr_ptr=0, lock=0, lock_id=0, tag FIFO count=0, rd/wr ptr=0, err=0.
  - With all s_valid=0 and r_valid=0, every output is 0.
- Issue side:
  - Issue is eligible when count<DEPTH.
  - Grant is the first i with s_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - d_valid = eligible & (any s_valid).
  - d_data = s_data of the granted requester.
  - s_ready[g] = d_ready & eligible for the granted g only; all other s_ready bits are 0.
- Grant stability:
  - If d_valid=1 and d_ready=0, set lock=1 and lock_id=g.
  - While lock=1, grant is forced to lock_id regardless of rr_ptr. d_data is stable because the requester must hold s_valid and s_data.
  - Lock clears on the handshake.
- On the issue handshake (d_valid & d_ready):
  - Push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NREQ.
- No same-cycle bypass when full: issue at count==DEPTH is blocked even if a result pops that cycle.
- Return side:
  - Head tag h = FIFO[rd].
  - m_valid[h] = r_valid & (count!=0); all other m_valid bits are 0.
  - r_ready = m_ready[h] & (count!=0).
  - m_data = r_data combinationally; no added latency on either path.
  - On the result handshake (r_valid & r_ready), pop the FIFO.
- Result with empty FIFO: if r_valid=1 while count==0, set err=1. err clears only on reset. r_ready stays 0, so the result is not consumed.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Pointers wrap mod DEPTH. count is width clog2(DEPTH)+1 and saturates at DEPTH through the eligibility rule.
- Reset mid-operation: in-flight tags are discarded. The pow8 instance shares rst, so its pipeline also clears; no stale results remain.
- A requester with m_ready low stalls the return path for all requesters, because returns are in order. Issue continues until count==DEPTH.

Optional Feature:
- POW8_ARB_FIXED_PRIO_EN defined:
  - Grant is fixed priority, lowest index wins.
  - rr_ptr logic is removed.
  - The grant lock rule still applies.
- Undefined: round-robin as specified above.

Test Plan:
- Single request: rst released; s_valid[2]=1, s_data[2]=3 → one d handshake with d_data=3. Result 6561 is returned on m_valid[2] only, m_data=64'd6561. err=0.
- Round-robin, all requesters active: all four s_valid=1 continuously with d_ready=1, data=i+1 → grants 0,1,2,3,0,… one per cycle. Results 1, 256, 6561, 65536 return to requesters 0..3 respectively. (Fixed-prio build: requester 0 granted every cycle.)
- Grant lock under stall: d_ready=0 for 5 cycles while requesters 1 and 3 are valid → d_data and the grant stay on requester 1 across all 5 cycles. After d_ready=1, requester 3 is granted next.
- Full FIFO: tie r_valid=0 and issue 8 requests → count=8, d_valid=0, all s_ready=0. Release one result → exactly one further issue is accepted, on the cycle after the pop.
- Return backpressure: result is for requester 1 with m_ready[1]=0 for 3 cycles → r_ready=0, m_valid[1] held, m_data stable. Handshake happens on the cycle m_ready[1] rises.
- Error and reset mid-flight:
  - r_valid=1 with count=0 → err=1 the next cycle and it stays 1.
  - Assert rst with 3 tags in flight → count=0, err=0, all outputs 0 immediately.
